// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard sequencer.
//               Holds the sequencer state encoding (RUN / MEM_WAIT) and the
//               default register-index width used by the NPC core.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  // Mirrors the core-wide register index width.
  localparam int REG_ADDR_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    STATE_RUN      = 2'd0,
    STATE_MEM_WAIT = 2'd1
  } state_t;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//               clr has priority over inc.
// Ports       : clk  - clock
//               rst  - synchronous active-low reset
//               inc  - count enable
//               clr  - synchronous clear
//               cnt  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central stall/flush sequencer for the 5-stage pipeline.
//               Combines LSU freeze, EX redirect, load-use and fetch-wait
//               hazards into one prioritised set of hold/clear strobes, and
//               keeps saturating stall/flush statistics plus a sticky LSU
//               timeout flag.
// Ports       : clk, rst (sync, active-low)
//               id_*          - ID-stage operand usage
//               ex_*          - EX-stage load / destination / redirect
//               lsu_req/done  - MEM-stage access handshake
//               if_valid      - fetch data valid
//               strobes       - pc/if_id/id_exe/ex_mem/mem_wb controls
//               state         - 0 = RUN, 1 = MEM_WAIT
//               stall_cnt, flush_cnt, mem_timeout - statistics / status
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH      = 32,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_raddr1,
  input  logic [REG_ADDR_WIDTH-1:0] id_raddr2,
  input  logic                      id_ren1,
  input  logic                      id_ren2,
  input  logic                      ex_mem_ren,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr,
  input  logic                      ex_redirect,
  input  logic                      lsu_req,
  input  logic                      lsu_done,
  input  logic                      if_valid,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_exe_stall,
  output logic                      hazard_clear_ctr,
  output logic                      bpu_clear_ctrl,
  output logic                      ex_mem_stall,
  output logic                      mem_wb_bubble,
  output logic [1:0]                state,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic                      mem_timeout
);

  localparam int               WAIT_WIDTH   = $clog2(MEM_TIMEOUT + 1);
  // The flag is registered, so it must be armed on the cycle whose edge
  // brings the wait count up to MEM_TIMEOUT.
  localparam logic [WAIT_WIDTH-1:0] TIMEOUT_LAST = WAIT_WIDTH'(MEM_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_mem_timeout;
  logic [WAIT_WIDTH-1:0] w_wait_cnt;
  logic                  w_freeze;
  logic                  w_load_use;
  logic                  w_in_wait;

  assign w_freeze  = lsu_req & ~lsu_done;
  assign w_in_wait = (r_state == STATE_MEM_WAIT);

  // x0 is hard-wired to zero, so a load targeting it can never create a
  // true dependency.
  assign w_load_use = id_valid & ex_mem_ren & (ex_reg_waddr != '0) &
                      ((id_ren1 & (id_raddr1 == ex_reg_waddr)) |
                       (id_ren2 & (id_raddr2 == ex_reg_waddr)));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= STATE_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and prioritised strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    pc_stall         = 1'b0;
    if_id_stall      = 1'b0;
    if_id_flush      = 1'b0;
    id_exe_stall     = 1'b0;
    hazard_clear_ctr = 1'b0;
    bpu_clear_ctrl   = 1'b0;
    ex_mem_stall     = 1'b0;
    mem_wb_bubble    = 1'b0;

    // Both states leave on the same condition: the wait ends either by
    // lsu_done or by the request being withdrawn.
    case (r_state)
      STATE_RUN:      w_state_nxt = w_freeze ? STATE_MEM_WAIT : STATE_RUN;
      STATE_MEM_WAIT: w_state_nxt = w_freeze ? STATE_MEM_WAIT : STATE_RUN;
      default:        w_state_nxt = STATE_RUN;
    endcase

    if (rst) begin
      if (w_freeze) begin
        // Whole pipe holds; a pending redirect stays latched in EX and is
        // serviced on the release cycle.
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_exe_stall  = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (ex_redirect) begin
        // PC is left running so it loads the redirect target.
        bpu_clear_ctrl = 1'b1;
        if_id_flush    = 1'b1;
      end else if (w_load_use) begin
        pc_stall         = 1'b1;
        if_id_stall      = 1'b1;
        hazard_clear_ctr = 1'b1;
      end else if (!if_valid) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_stall),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bpu_clear_ctrl),
    .clr (1'b0),
    .cnt (flush_cnt)
  );

  sat_counter #(.WIDTH(WAIT_WIDTH)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_in_wait),
    .clr (~w_in_wait & w_freeze),
    .cnt (w_wait_cnt)
  );

  // Sticky until reset; it only reports, it never releases the freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_timeout <= 1'b0;
    end else if (w_in_wait && (w_wait_cnt >= TIMEOUT_LAST)) begin
      r_mem_timeout <= 1'b1;
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign state       = r_state;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Directed scenarios
//               followed by randomized traffic, all compared against a
//               cycle-level reference model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int RAW  = 5;
  localparam int CW   = 8;
  localparam int MT   = 4;
  localparam longint SAT = (longint'(1) << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid;
  logic [RAW-1:0] id_raddr1, id_raddr2;
  logic           id_ren1, id_ren2;
  logic           ex_mem_ren;
  logic [RAW-1:0] ex_reg_waddr;
  logic           ex_redirect;
  logic           lsu_req, lsu_done;
  logic           if_valid;
  logic           pc_stall, if_id_stall, if_id_flush, id_exe_stall;
  logic           hazard_clear_ctr, bpu_clear_ctrl, ex_mem_stall, mem_wb_bubble;
  logic [1:0]     state;
  logic [CW-1:0]  stall_cnt, flush_cnt;
  logic           mem_timeout;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH (RAW),
    .CNT_WIDTH      (CW),
    .MEM_TIMEOUT    (MT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_raddr1        (id_raddr1),
    .id_raddr2        (id_raddr2),
    .id_ren1          (id_ren1),
    .id_ren2          (id_ren2),
    .ex_mem_ren       (ex_mem_ren),
    .ex_reg_waddr     (ex_reg_waddr),
    .ex_redirect      (ex_redirect),
    .lsu_req          (lsu_req),
    .lsu_done         (lsu_done),
    .if_valid         (if_valid),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .if_id_flush      (if_id_flush),
    .id_exe_stall     (id_exe_stall),
    .hazard_clear_ctr (hazard_clear_ctr),
    .bpu_clear_ctrl   (bpu_clear_ctrl),
    .ex_mem_stall     (ex_mem_stall),
    .mem_wb_bubble    (mem_wb_bubble),
    .state            (state),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt),
    .mem_timeout      (mem_timeout)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  bit     m_wait  = 0;
  int     m_wcnt  = 0;
  longint m_stall = 0;
  longint m_flush = 0;
  bit     m_to    = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Strobe vector order:
  // {pc, if_id_stall, if_id_flush, id_exe_stall, hazard_clr, bpu_clr, ex_mem_stall, mem_wb_bubble}
  function automatic logic [7:0] exp_strobes();
    bit fr, lu;
    if (!rst) return 8'b0000_0000;
    fr = lsu_req && !lsu_done;
    lu = id_valid && ex_mem_ren && (ex_reg_waddr != 0) &&
         ((id_ren1 && id_raddr1 == ex_reg_waddr) || (id_ren2 && id_raddr2 == ex_reg_waddr));
    if (fr)           return 8'b1101_0011;
    if (ex_redirect)  return 8'b0010_0100;
    if (lu)           return 8'b1100_1000;
    if (!if_valid)    return 8'b1010_0000;
    return 8'b0000_0000;
  endfunction

  task automatic step(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    bit         fr;
    #2;
    e = exp_strobes();
    g = {pc_stall, if_id_stall, if_id_flush, id_exe_stall,
         hazard_clear_ctr, bpu_clear_ctrl, ex_mem_stall, mem_wb_bubble};
    check({tag, ".strobes"}, g, e);
    check({tag, ".state"}, state, m_wait ? 1 : 0);
    check({tag, ".stall_cnt"}, stall_cnt, m_stall);
    check({tag, ".flush_cnt"}, flush_cnt, m_flush);
    check({tag, ".timeout"}, mem_timeout, m_to);
    // advance model to the next edge
    if (!rst) begin
      m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_to = 0;
    end else begin
      fr = lsu_req && !lsu_done;
      if (e[7] && m_stall < SAT) m_stall++;
      if (e[2] && m_flush < SAT) m_flush++;
      if (m_wait) begin
        m_wcnt++;
        if (m_wcnt >= MT) m_to = 1;
      end else if (fr) begin
        m_wcnt = 0;
      end
      m_wait = fr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; id_valid = 1'b0; id_raddr1 = '0; id_raddr2 = '0;
    id_ren1 = 1'b0; id_ren2 = 1'b0; ex_mem_ren = 1'b0; ex_reg_waddr = '0;
    ex_redirect = 1'b0; lsu_req = 1'b0; lsu_done = 1'b0; if_valid = 1'b1;
  endtask

  initial begin
    idle();
    // reset with a fetch stall pending: strobes must still be forced low
    rst = 1'b0; if_valid = 1'b0;
    step("rst0"); step("rst1");

    // load-use on rs2
    idle();
    id_valid = 1'b1; ex_mem_ren = 1'b1; ex_reg_waddr = 5'd5;
    id_raddr2 = 5'd5; id_ren2 = 1'b1;
    step("lu");
    ex_mem_ren = 1'b0;
    step("lu_after");
    check("lu.cnt_is_1", stall_cnt, 1);

    // x0 destination never stalls
    idle();
    id_valid = 1'b1; ex_mem_ren = 1'b1; ex_reg_waddr = '0;
    id_raddr1 = '0; id_ren1 = 1'b1;
    step("x0");

    // same-cycle req/done in RUN: no freeze
    idle();
    lsu_req = 1'b1; lsu_done = 1'b1;
    step("reqdone");

    // LSU wait: 4 cycles of req, done on the 4th
    idle();
    lsu_req = 1'b1;
    step("lsu1"); step("lsu2"); step("lsu3");
    lsu_done = 1'b1;
    step("lsu4");
    idle();
    step("lsu5");
    check("lsu.cnt_is_4", stall_cnt, 4);

    // redirect deferred across a 2-cycle freeze
    idle();
    lsu_req = 1'b1; ex_redirect = 1'b1;
    step("defer1"); step("defer2");
    lsu_done = 1'b1;
    step("defer_rel");
    idle();
    step("defer_after");
    check("defer.flush_is_1", flush_cnt, 1);

    // redirect plus load-use: only redirect
    idle();
    ex_redirect = 1'b1; id_valid = 1'b1; ex_mem_ren = 1'b1;
    ex_reg_waddr = 5'd7; id_raddr1 = 5'd7; id_ren1 = 1'b1;
    step("redir_lu");

    // timeout
    idle();
    lsu_req = 1'b1;
    for (int i = 0; i < 6; i++) step("to_wait");
    check("to.set", mem_timeout, 1);
    lsu_done = 1'b1;
    step("to_rel");
    idle();
    step("to_after");
    check("to.sticky", mem_timeout, 1);

    // reset in the middle of a wait
    idle();
    lsu_req = 1'b1;
    step("rmw1"); step("rmw2");
    rst = 1'b0;
    step("rmw_rst1"); step("rmw_rst2");
    check("rmw.state", state, 0);
    check("rmw.stall", stall_cnt, 0);
    check("rmw.timeout", mem_timeout, 0);

    // randomized traffic
    idle();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(399) != 0);
      id_valid     = ($urandom_range(3) != 0);
      id_raddr1    = RAW'($urandom_range(3));
      id_raddr2    = RAW'($urandom_range(3));
      id_ren1      = ($urandom_range(1) != 0);
      id_ren2      = ($urandom_range(1) != 0);
      ex_mem_ren   = ($urandom_range(1) != 0);
      ex_reg_waddr = RAW'($urandom_range(3));
      ex_redirect  = ($urandom_range(7) == 0);
      if_valid     = ($urandom_range(7) != 0);
      if (lsu_req && !lsu_done) lsu_req = ($urandom_range(9) != 0);
      else                      lsu_req = ($urandom_range(9) < 3);
      lsu_done     = ($urandom_range(3) == 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage NPC pipeline. It resolves load-use hazards, multi-cycle LSU waits, EX-stage redirects (branch/jump) and fetch waits into one prioritised set of hold/clear strobes. These strobes drive the PC, IF/ID, ID/EX (`hazard_clear_ctr`, `bpu_clear_ctrl`, hold) and EX/MEM/WB pipeline registers. It also keeps saturating stall/flush statistics and a sticky LSU timeout flag.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register index width
- `CNT_WIDTH`, 32, statistics counter width
- `MEM_TIMEOUT`, 255, LSU wait cycles before `mem_timeout` sets (≥2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_raddr1`, `id_raddr2`  in  `REG_ADDR_WIDTH`  ID source registers
- `id_ren1`, `id_ren2`  in  1  ID instruction actually reads rs1/rs2
- `ex_mem_ren`  in  1  instruction in EX is a load (ID/EX `mem_ren`)
- `ex_reg_waddr`  in  `REG_ADDR_WIDTH`  EX destination register
- `ex_redirect`  in  1  EX resolved a taken branch/jump mispredict
- `lsu_req`  in  1  MEM stage has an access outstanding
- `lsu_done`  in  1  LSU completes the access this cycle
- `if_valid`  in  1  fetch data valid this cycle
- `pc_stall`  out  1  hold PC
- `if_id_stall`  out  1  hold IF/ID
- `if_id_flush`  out  1  load bubble into IF/ID
- `id_exe_stall`  out  1  hold ID/EX
- `hazard_clear_ctr`  out  1  insert bubble into ID/EX (load-use)
- `bpu_clear_ctrl`  out  1  redirect flush of IF/ID/EX
- `ex_mem_stall`  out  1  hold EX/MEM
- `mem_wb_bubble`  out  1  write bubble into MEM/WB
- `state`  out  2  FSM state (RUN=0, MEM_WAIT=1)
- `stall_cnt`, `flush_cnt`  out  `CNT_WIDTH`  statistics
- `mem_timeout`  out  1  sticky LSU timeout flag

## Operation
- Hazard terms:
  - `load_use` = `id_valid & ex_mem_ren & ex_reg_waddr!=0 & ((id_ren1 & id_raddr1==ex_reg_waddr) | (id_ren2 & id_raddr2==ex_reg_waddr))`.
  - `freeze` = `lsu_req & !lsu_done`.
- Strict priority. The first matching condition sets outputs; all others are 0.
  1. `freeze`: `pc_stall`, `if_id_stall`, `id_exe_stall`, `ex_mem_stall`, `mem_wb_bubble` = 1. Redirect and load-use are deferred. EX is held, so `ex_redirect` stays asserted and is serviced on the release cycle.
  2. `ex_redirect`: `bpu_clear_ctrl` = 1 and `if_id_flush` = 1. `pc_stall` = 0 so the PC loads the target. Load-use is ignored because the ID instruction is killed.
  3. `load_use`: `pc_stall` = 1, `if_id_stall` = 1, `hazard_clear_ctr` = 1. This inserts exactly one bubble; the load advances to MEM on the next cycle.
  4. `!if_valid`: `pc_stall` = 1, `if_id_flush` = 1.
- FSM:
  - RUN → MEM_WAIT when `freeze`.
  - MEM_WAIT → RUN on the cycle `lsu_done` = 1. That cycle is the release cycle: freeze outputs are 0 and priorities 2–4 apply.
  - MEM_WAIT stays while `!lsu_done`. A drop of `lsu_req` without `lsu_done` also returns to RUN.
- Wait counter:
  - Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle; saturates.
  - When it reaches `MEM_TIMEOUT`, `mem_timeout` sets and remains set until reset. The freeze is not released by the timeout.
- Statistics:
  - `stall_cnt` increments on every cycle with `pc_stall` = 1.
  - `flush_cnt` increments on every cycle with `bpu_clear_ctrl` = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- All strobes are combinational from the current inputs and registered state, with zero latency. They are sampled by the pipeline registers at the same edge.
- `state`, wait counter, `stall_cnt`, `flush_cnt` and `mem_timeout` are registered and update at the edge after the causing cycle.
- Reset (`rst` = 0 at an edge, including mid-MEM_WAIT):
  - `state` = RUN; wait counter, `stall_cnt`, `flush_cnt` = 0; `mem_timeout` = 0.
  - While `rst` = 0, all strobe outputs are forced to 0.
- Boundary cases:
  - `lsu_req` and `lsu_done` in the same RUN cycle: no freeze and no state change.
  - Redirect and load-use together: only redirect is serviced.
  - x0 destination never triggers load-use.

## Structure
- Shared package: `STATE_RUN`/`STATE_MEM_WAIT` encodings and the state typedef. The width macros reuse the `define.vh` `REG_ADDR_WIDTH`.
- One sub-module, `sat_counter` (param width, inc, clr), instantiated for `stall_cnt`, `flush_cnt` and the wait counter.
- ID/EX register gains an `id_exe_stall` hold input. The clear inputs take priority over hold.

## Test plan
- Load-use: EX load `ex_reg_waddr` = 5, ID `id_raddr2` = 5 with `id_ren2` = 1 → exactly one cycle of `pc_stall` = `if_id_stall` = `hazard_clear_ctr` = 1; `stall_cnt` 0 → 1.
- x0 load: `ex_reg_waddr` = 0 with matching `id_raddr1` = 0 → no stall.
- LSU wait: `lsu_req` = 1 for 4 cycles, `lsu_done` on the 4th → freeze for 3 cycles, `state` = 1 for cycles 2–4, RUN after; `stall_cnt` = 3.
- Deferred redirect: `ex_redirect` = 1 during a 2-cycle freeze → `bpu_clear_ctrl` = 0 while frozen, = 1 on the release cycle; `flush_cnt` = 1.
- Timeout: `MEM_TIMEOUT` = 4, `lsu_req` held with no `lsu_done` → `mem_timeout` = 1 after the 4th MEM_WAIT cycle, still 1 after `lsu_done`.
- Reset mid-wait: `rst` = 0 during MEM_WAIT → next edge `state` = 0, counters 0, all strobes 0 while reset is held.
